// File: rtl/display_refresh_scheduler_pkg.sv
// display_refresh_scheduler_pkg: shared FSM state encoding and segment packing for the display scheduler
package display_refresh_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, CFG_REQ, CFG_WAIT, DIG_REQ, DIG_WAIT, DONE} state_e;
  localparam logic [3:0] SEG_PAD = 4'h0;
  function automatic logic [7:0] seg_pack(input logic [3:0] nib);
    return {SEG_PAD, nib};
  endfunction
endpackage

// File: rtl/display_refresh_scheduler.sv
// display_refresh_scheduler: sequences config and BCD digit writes to a settings driver with per-transaction timeout
module display_refresh_scheduler
  import display_refresh_scheduler_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_refresh_stb,
  input  logic                    i_config_dirty,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic                    o_stb,
  output logic                    o_write_config,
  output logic [2:0]              o_digit,
  output logic [7:0]              o_segment,
  input  logic                    i_busy,
  input  logic                    i_ack
);
  state_e                  state_q;
  logic [2:0]              idx_q;
  logic [TO_W-1:0]         to_q;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [7:0]              seg_q;
  logic                    stb_q, done_q, error_q, wc_q;
  logic                    frame_pend_q, cfg_pend_q, cfg_trig_q;
  logic                    start, to_hit, in_req, in_wait, fail;
  logic [3:0]              nxt_nib;
  // cfg_pend_q marks the config as stale; only cfg_trig_q (a real dirty pulse) may launch a frame on its own
  assign start   = frame_pend_q | cfg_trig_q | i_refresh_stb | i_config_dirty;
  assign to_hit  = to_q == TO_W'(TIMEOUT - 1);
  assign in_req  = state_q == CFG_REQ || state_q == DIG_REQ;
  assign in_wait = state_q == CFG_WAIT || state_q == DIG_WAIT;
  assign fail    = (in_req && !i_busy && to_hit) || (in_wait && (i_busy ? to_hit : !i_ack));
  assign nxt_nib = 4'(snap_q >> (4 * (idx_q + 3'd1)));
  assign o_busy         = state_q != IDLE;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_stb          = stb_q;
  assign o_write_config = wc_q;
  assign o_digit        = idx_q;
  assign o_segment      = seg_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      to_q         <= '0;
      snap_q       <= '0;
      seg_q        <= '0;
      stb_q        <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wc_q         <= 1'b0;
      frame_pend_q <= 1'b0;
      cfg_pend_q   <= 1'b1;
      cfg_trig_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      to_q   <= to_q + 1'b1;
      if (i_refresh_stb) frame_pend_q <= 1'b1;
      if (i_config_dirty) begin
        cfg_pend_q <= 1'b1;
        cfg_trig_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: if (start) begin
          snap_q       <= i_digits;
          frame_pend_q <= 1'b0;
          cfg_trig_q   <= 1'b0;
          idx_q        <= '0;
          to_q         <= '0;
          stb_q        <= 1'b1;
          if (cfg_pend_q | cfg_trig_q | i_config_dirty) begin
            state_q <= CFG_REQ;
            wc_q    <= 1'b1;
          end else begin
            state_q <= DIG_REQ;
            wc_q    <= 1'b0;
            seg_q   <= seg_pack(i_digits[3:0]);
          end
        end
        CFG_REQ: if (i_busy) begin
          stb_q      <= 1'b0;
          cfg_pend_q <= i_config_dirty;
          to_q       <= '0;
          state_q    <= CFG_WAIT;
        end
        CFG_WAIT: if (!i_busy && i_ack) begin
          state_q <= DIG_REQ;
          idx_q   <= '0;
          to_q    <= '0;
          stb_q   <= 1'b1;
          wc_q    <= 1'b0;
          seg_q   <= seg_pack(snap_q[3:0]);
        end
        DIG_REQ: if (i_busy) begin
          stb_q   <= 1'b0;
          to_q    <= '0;
          state_q <= DIG_WAIT;
        end
        DIG_WAIT: if (!i_busy && i_ack) begin
          if (idx_q == 3'(NUM_DIGITS - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 3'd1;
            to_q    <= '0;
            stb_q   <= 1'b1;
            seg_q   <= seg_pack(nxt_nib);
            state_q <= DIG_REQ;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (fail) begin
        state_q    <= IDLE;
        stb_q      <= 1'b0;
        error_q    <= 1'b1;
        cfg_pend_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_refresh_scheduler.sv
// tb_display_refresh_scheduler: scoreboard bench with a behavioural settings-driver model
module tb_display_refresh_scheduler;
  logic        clk = 1'b0, rst = 1'b1, refresh = 1'b0, dirty = 1'b0;
  logic        busy_m = 1'b0, ack_m = 1'b0;
  logic [23:0] digits = '0;
  logic        o_busy, o_done, o_error, o_stb, o_write_config;
  logic [2:0]  o_digit;
  logic [7:0]  o_segment;
  int          n_vec = 0, n_miss = 0, done_cnt = 0, cnt_m = 0;
  bit          connected = 1'b1;
  logic [12:0] exp_q[$];
  always #5 clk = ~clk;
  display_refresh_scheduler #(.NUM_DIGITS(6), .TIMEOUT(255), .TO_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_refresh_stb(refresh), .i_config_dirty(dirty),
    .i_digits(digits), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_stb(o_stb), .o_write_config(o_write_config), .o_digit(o_digit),
    .o_segment(o_segment), .i_busy(busy_m), .i_ack(ack_m)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // driver model: accepts a request, stays busy three cycles, then acks as busy falls
  always @(negedge clk) begin : drv
    logic [12:0] w;
    if (o_done) done_cnt++;
    ack_m = 1'b0;
    if (rst) begin
      busy_m = 1'b0;
      cnt_m  = 0;
    end else if (busy_m) begin
      cnt_m--;
      if (cnt_m == 0) begin
        busy_m = 1'b0;
        ack_m  = 1'b1;
      end
    end else if (o_stb && connected) begin
      w = o_write_config ? 13'h1800 : {2'b10, o_digit, o_segment};
      if (exp_q.size() > 0) chk("write", w, exp_q.pop_front());
      else chk("extra_write", w, 0);
      busy_m = 1'b1;
      cnt_m  = 3;
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask
  task automatic push_frame(input bit cfg, input logic [23:0] d, input int n);
    if (cfg) exp_q.push_back(13'h1800);
    for (int i = 0; i < n; i++) exp_q.push_back({2'b10, 3'(i), 4'h0, d[4*i +: 4]});
  endtask
  task automatic wait_frames(input string tag, input int n);
    int s, k;
    s = done_cnt;
    k = 0;
    while (done_cnt < s + n && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, done_cnt - s, n);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask
  task automatic wait_dig(input logic [2:0] d);
    int k;
    k = 0;
    while (!(o_stb && !o_write_config && o_digit == d) && k < 3000) begin
      tick();
      k++;
    end
    chk("reach_digit", {o_stb, o_digit}, {1'b1, d});
  endtask
  initial begin : main
    int k, s, d0;
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_stb", o_stb, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_error, 0);
    chk("rst_wc", o_write_config, 0);
    chk("rst_digit", o_digit, 0);
    chk("rst_seg", o_segment, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_after_rst", o_busy, 0);
    digits = 24'h123456;
    push_frame(1, digits, 6);
    pulse_refresh();
    chk("busy_in_frame", o_busy, 1);
    chk("cfg_first", o_write_config, 1);
    wait_frames("f1", 1);
    tick();
    chk("idle_after_f1", o_busy, 0);
    push_frame(0, digits, 6);
    pulse_refresh();
    chk("f2_no_cfg", o_write_config, 0);
    wait_frames("f2", 1);
    digits = 24'h654321;
    push_frame(0, digits, 6);
    pulse_refresh();
    wait_dig(3'd2);
    dirty = 1'b1;
    push_frame(1, digits, 6);
    tick();
    dirty = 1'b0;
    wait_frames("dirty", 2);
    digits = 24'h123456;
    push_frame(0, digits, 6);
    pulse_refresh();
    wait_dig(3'd1);
    digits = 24'h999999;
    wait_frames("snap", 1);
    digits = 24'h123456;
    push_frame(0, digits, 3);
    pulse_refresh();
    k = 0;
    while (!(o_stb && !o_write_config && o_digit == 3'd3) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_d3", {o_stb, o_digit}, {1'b1, 3'd3});
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_stb", o_stb, 0);
    chk("rst_mid_idle", o_busy, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_mid_no_done", done_cnt, d0);
    chk("rst_mid_sb_empty", exp_q.size(), 0);
    connected = 1'b0;
    pulse_refresh();
    s = 0;
    k = 0;
    while (!o_error && k < 600) begin
      if (o_stb) s++;
      tick();
      k++;
    end
    chk("to_err", o_error, 1);
    chk("to_stb", o_stb, 0);
    chk("to_busy", o_busy, 0);
    chk("to_stb_cycles", s, 255);
    repeat (5) tick();
    chk("err_sticky", o_error, 1);
    chk("to_stay_idle", o_busy, 0);
    chk("to_no_done", done_cnt, d0);
    rst = 1'b1;
    repeat (2) tick();
    chk("err_clr", o_error, 0);
    rst = 1'b0;
    connected = 1'b1;
    tick();
    push_frame(1, digits, 6);
    pulse_refresh();
    wait_frames("post_rst", 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
